// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive path: state encoding and default frame width.
package uart_rx_ctrl_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_sync_edge.sv
// Brings the asynchronous rxd line into the clk domain and flags its falling edges.
module rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 1 so a line that is already idle never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_s      = sync_q[SYNC_STAGES-1];
    assign fall_pulse = prev_q & ~rxd_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: start detect, mid-bit sampling on clk_bps, deframing.
//  state   | meaning
//  S_IDLE  | line idle, waiting for falling edge of rxd_s
//  S_START | baud generator running, waiting to confirm start bit mid-bit
//  S_DATA  | shifting in data bits LSB first
//  S_STOP  | waiting to sample the stop bit
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 clk_bps,
    output logic                 band_sig,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0]     bit_cnt, cnt_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 band_nxt, valid_nxt, ferr_nxt, busy_nxt;
    logic                 rxd_s, fall_pulse;

    rx_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rxd_s      (rxd_s),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            band_sig  <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            rx_data   <= data_nxt;
            band_sig  <= band_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
            rx_busy   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        data_nxt  = rx_data;
        band_nxt  = band_sig;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (fall_pulse) begin
                    state_nxt = S_START;
                    band_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (clk_bps) begin
                    if (rxd_s) begin
                        state_nxt = S_IDLE;
                        band_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_DATA;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (clk_bps) begin
                    shift_nxt = {rxd_s, shift_reg[DATA_BITS-1:1]};
                    // Hold the counter on the last bit so it never wraps.
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = S_STOP;
                    end else begin
                        cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (clk_bps) begin
                    state_nxt = S_IDLE;
                    band_nxt  = 1'b0;
                    if (rxd_s) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                band_nxt  = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl paired with a behavioural baud generator (CNT_BAND=10).
module tb_uart_rx_ctrl;

    localparam int CNT_BAND = 10;
    localparam int BIT_CLK  = CNT_BAND + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       extra_bps = 1'b0;
    logic       gen_bps;
    logic       clk_bps;
    logic       band_sig;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
    logic [3:0] band_cnt;

    int   n_pass  = 0;
    int   n_total = 0;
    ev_t  exp_q[$];
    logic [7:0] model_last = 8'h00;

    always #5 clk = ~clk;

    // Baud generator: counts 0..CNT_BAND while enabled, strobe at the half period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            band_cnt <= '0;
        else if (!band_sig || band_cnt == 4'(CNT_BAND))
            band_cnt <= '0;
        else
            band_cnt <= band_cnt + 4'd1;
    end
    assign gen_bps = band_sig && (band_cnt == 4'(CNT_BAND / 2));
    assign clk_bps = gen_bps | extra_bps;

    uart_rx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .clk_bps   (clk_bps),
        .band_sig  (band_sig),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err)) begin
            ev_t e;
            check("strobes_exclusive", 32'(rx_valid & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, frame_err, rx_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(frame_err), 32'(e.is_err));
                check("rx_data", 32'(rx_data), 32'(e.data));
            end
        end
    end

    // Reference: a good stop delivers the byte, a bad stop reports an error and keeps the last good byte.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int bits_sent = 10);
        if (bits_sent == 10) begin
            if (stop) begin
                exp_q.push_back('{1'b0, d});
                model_last = d;
            end else begin
                exp_q.push_back('{1'b1, model_last});
            end
        end
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8 && i < bits_sent - 1; i++) begin
            rxd = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (bits_sent == 10) begin
            rxd = stop;
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_band_sig", 32'(band_sig), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_strobes", {30'd0, rx_valid, frame_err}, 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single 0x55 frame
        send_frame(8'h55, 1'b1);
        repeat (5) @(negedge clk);
        wait_drain("t1_drain");
        check("t1_rx_data", 32'(rx_data), 32'h55);
        check("t1_band_low", 32'(band_sig), 32'd0);
        check("t1_busy_low", 32'(rx_busy), 32'd0);

        // 2: back-to-back frames
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        repeat (5) @(negedge clk);
        wait_drain("t2_drain");
        check("t2_rx_data", 32'(rx_data), 32'h0F);

        // 3: bad stop bit then line held low
        send_frame(8'hC4, 1'b0);
        repeat (30) @(negedge clk);
        wait_drain("t3_drain");
        check("t3_rx_data_held", 32'(rx_data), 32'h0F);
        check("t3_no_retrigger_busy", 32'(rx_busy), 32'd0);
        check("t3_no_retrigger_band", 32'(band_sig), 32'd0);
        rxd = 1'b1;
        repeat (15) @(negedge clk);

        // 4: short glitch is rejected at the start-bit check
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        check("t4_band_high", 32'(band_sig), 32'd1);
        check("t4_busy_high", 32'(rx_busy), 32'd1);
        repeat (20) @(negedge clk);
        check("t4_band_low", 32'(band_sig), 32'd0);
        check("t4_busy_low", 32'(rx_busy), 32'd0);
        check("t4_no_event", 32'(exp_q.size()), 32'd0);

        // 5: reset in the middle of the data bits
        send_frame(8'h99, 1'b1, 6);
        check("t5_busy_before", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_band_rst", 32'(band_sig), 32'd0);
        check("t5_data_rst", 32'(rx_data), 32'd0);
        check("t5_busy_rst", 32'(rx_busy), 32'd0);
        check("t5_strobes_rst", {30'd0, rx_valid, frame_err}, 32'd0);
        model_last = 8'h00;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        repeat (5) @(negedge clk);
        wait_drain("t5_drain");
        check("t5_rx_data", 32'(rx_data), 32'h7E);

        // 6: stray clk_bps while idle
        for (int i = 0; i < 4; i++) begin
            extra_bps = 1'b1;
            @(negedge clk);
            extra_bps = 1'b0;
            @(negedge clk);
            check("t6_busy", 32'(rx_busy), 32'd0);
            check("t6_band", 32'(band_sig), 32'd0);
        end

        // Randomized frames with occasional bad stop bits and random gaps
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            bit         stop;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            rxd = 1'b1;
            if (!stop)
                repeat (BIT_CLK) @(negedge clk);
            else
                repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        wait_drain("rand_drain");
        check("rand_rx_data", 32'(rx_data), 32'(model_last));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
